reg_file_mp: RTL
================

# reg_file_mp

Parametrised multi-port register file for the pipelined core. It replaces the fixed 32x32 two-read/one-write bank with configurable width, depth and read-port count. It adds a second write port, write-to-read bypass, an asynchronous clear and a per-register pending-write scoreboard, which the decode stage uses for hazard detection. It sits between decode (reads, scoreboard set) and writeback (write ports).

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of registers (>= 2)
- NUM_RD, 2, number of combinational read ports (>= 1)
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads
- ZERO_REG, 1, 1 = register 0 is hardwired to zero
- AW (localparam) = $clog2(NUM_REGS)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*AW  read addresses; port k is bits [k*AW +: AW]
- rd_data  out  NUM_RD*DW  read data; port k is bits [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port k's register has a pending write
- wr0_en  in  1  write port 0 enable (low priority)
- wr0_addr  in  AW  write port 0 address
- wr0_data  in  DATA_W  write port 0 data
- wr1_en  in  1  write port 1 enable (high priority)
- wr1_addr  in  AW  write port 1 address
- wr1_data  in  DATA_W  write port 1 data
- sb_set_en  in  1  mark a destination register as pending (issue)
- sb_set_addr  in  AW  register to mark pending

## Operation
- Storage: NUM_REGS x DATA_W flops plus a NUM_REGS-bit scoreboard `pend`.
- Reset (rst_n low, asynchronous): every register clears to 0 and every pend bit clears to 0.
  - Outputs during reset: rd_data = 0 and rd_busy = 0, unless BYPASS forwards a same-cycle write.
  - Writes and sets are ignored while rst_n is low.
- Write:
  - On a rising edge with wrX_en = 1, wrX_data is stored at wrX_addr.
  - If both ports target the same address, port 1's data is stored.
- Scoreboard clear: any enabled write to address A clears pend[A] at that edge.
- Scoreboard set: sb_set_en = 1 sets pend[sb_set_addr] at the edge.
  - If a set and a clearing write hit the same address in the same cycle, the set wins and pend stays 1. The new producer has been issued after the old writeback.
- Register 0 when ZERO_REG = 1:
  - Writes to address 0 are dropped.
  - sb_set to address 0 is dropped.
  - Reads of address 0 return 0 with busy = 0, including under bypass.
- Out-of-range address (>= NUM_REGS, possible only for a non-power-of-two depth):
  - Writes and sets are ignored.
  - Reads return 0 with busy = 0.
- Read port k (purely combinational):
  - BYPASS = 1 and wr1 matches rd_addr_k: rd_data = wr1_data and rd_busy = 0.
  - Otherwise, BYPASS = 1 and wr0 matches rd_addr_k: rd_data = wr0_data and rd_busy = 0.
  - Otherwise: rd_data = stored value and rd_busy = pend[addr].
  - "Matches" means the port is enabled, its address equals rd_addr_k, and the address is legal (not register 0 when ZERO_REG = 1, and < NUM_REGS).
  - With BYPASS = 0, reads always return the stored value and pend. A write becomes visible on the cycle after its edge.
  - The scoreboard set never affects reads in its own cycle; the busy bit appears the cycle after sb_set_en.

## Timing
- Write latency: 1 edge to storage.
- Read latency: 0 cycles (combinational path from address to data).
- Bypass path: a combinational path from wrX_data to rd_data exists only when BYPASS = 1.
- Scoreboard set and clear: effective at the next rising edge.
- Reset assertion: asynchronous, so outputs go to their reset values without waiting for a clock edge.
- Reset deassertion: the first state-changing edge is the first rising edge with rst_n high.
- Reset mid-operation: a write or set in the same cycle as the reset assertion is lost.
- No handshakes: the caller guarantees wr_addr, wr_data and the enables are stable around the rising edge.

## Test plan
- Reset, then walk all registers:
  - Stimulus: hold rst_n low, then read every address on all ports. Then write 0xA5A50000+i to reg i (i = 1..31) via wr0 and read each back with BYPASS = 0.
  - Required: all reads return 0 during reset. Every readback returns 0xA5A50000+i, and reg 0 reads 0.
- Write-port collision:
  - Stimulus: in one cycle, wr0 writes reg 5 = 0x11111111 and wr1 writes reg 5 = 0x22222222.
  - Required: next cycle reg 5 reads 0x22222222. With BYPASS = 1, the same-cycle read of reg 5 also returns 0x22222222.
- Bypass:
  - Stimulus: BYPASS = 1; wr0 writes reg 7 = 0xDEADBEEF while rd port 1 reads reg 7.
  - Required: rd_data1 = 0xDEADBEEF in the same cycle. With BYPASS = 0, the same-cycle read returns the old value and the next cycle returns 0xDEADBEEF.
- Scoreboard:
  - Stimulus: sb_set reg 9, then two idle cycles, then wr1 writes reg 9. Separately, sb_set and a write to reg 12 in the same cycle.
  - Required:
    - rd_busy for reg 9 is 0 in the set cycle and 1 in the next two cycles.
    - With BYPASS = 1, busy is 0 in the write cycle; it is 0 from the next cycle onward in either mode.
    - pend[12] = 1 after the simultaneous set and write.
- Zero register and mid-operation reset:
  - Stimulus: write reg 0 = 0xFFFFFFFF and sb_set reg 0. Separately, pull rst_n low mid-cycle with reg 3 = 0x1234 and pend[3] = 1.
  - Required: reg 0 reads 0 and is never busy. On the rst_n fall, rd_data for reg 3 becomes 0 and busy becomes 0 immediately, without a clock edge.
- Parametrised build:
  - Stimulus: NUM_REGS = 24, NUM_RD = 3, DATA_W = 64.
  - Required: writes to address 30 are ignored and reads of address 30 return 0. All 3 ports independently read 64-bit values written to regs 1, 12 and 23.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports, N combinational read ports, optional write-to-read bypass, pending-write scoreboard.
// Latency: writes and scoreboard updates land on the next edge, reads are combinational; no backpressure, the caller holds inputs stable.
module reg_file_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [AW-1:0]            wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [AW-1:0]            wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     sb_set_en,
    input  logic [AW-1:0]            sb_set_addr
);

    localparam logic [AW:0] NREGS = (AW+1)'(NUM_REGS);

    // Legal = backed by a real register and not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    logic wr0_ok;
    logic wr1_ok;
    logic set_ok;

    assign wr0_ok = wr0_en    && addr_ok(wr0_addr);
    assign wr1_ok = wr1_en    && addr_ok(wr1_addr);
    assign set_ok = sb_set_en && addr_ok(sb_set_addr);

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        localparam logic [AW-1:0] RA = AW'(r);
        logic hit0;
        logic hit1;
        logic hit_s;

        assign hit0  = wr0_ok && (wr0_addr == RA);
        assign hit1  = wr1_ok && (wr1_addr == RA);
        assign hit_s = set_ok && (sb_set_addr == RA);

        assign regs_d[r] = hit1 ? wr1_data : (hit0 ? wr0_data : regs_q[r]);
        // A new issue to the same register outranks the older producer's writeback.
        assign pend_d[r] = hit_s | (pend_q[r] & ~(hit0 | hit1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          ok;
        logic          fwd1;
        logic          fwd0;

        assign ra   = rd_addr[k*AW +: AW];
        assign ok   = addr_ok(ra);
        assign fwd1 = (BYPASS != 0) && wr1_en && (wr1_addr == ra) && ok;
        assign fwd0 = (BYPASS != 0) && wr0_en && (wr0_addr == ra) && ok;

        assign rd_data[k*DATA_W +: DATA_W] = fwd1 ? wr1_data :
                                             fwd0 ? wr0_data :
                                             ok   ? regs_q[ra] : '0;
        assign rd_busy[k] = !(fwd1 || fwd0) && ok && pend_q[ra];
    end

endmodule
